mips_muldiv_ctrl: RTL and testbench
===================================

# mips_muldiv_ctrl

Sequencing controller for the execute-stage multiply/divide resource. Accepts one HI/LO-class operation at a time from the EX stage, latches the operands, starts the multiplier (fixed latency) or the iterative divider (done-handshake), and owns the architectural HI/LO registers. It exposes a ready/busy handshake for EX-stage stalling, and supports flush-cancel so squashed instructions never update HI/LO.

## Interface
Parameters:
- MUL_LAT, 2: cycles from the `mul_start` cycle to a valid `mul_result`; legal range 1..15.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- req_valid  in  1  EX stage presents an operation
- req_op  in  3  operation code: 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved
- req_x  in  32  rs operand
- req_y  in  32  rt operand
- req_ready  out  1  request accepted this cycle if `req_valid` is high
- flush  in  1  cancel the in-flight or presented operation
- op_x  out  32  latched operand to the mult/div units
- op_y  out  32  latched operand to the mult/div units
- mul_start  out  1  one-cycle start pulse to the multiplier
- mul_signed  out  1  signed multiply
- mul_result  in  64  multiplier product
- div_start  out  1  one-cycle start pulse to the divider
- div_signed  out  1  signed divide
- div_cancel  out  1  one-cycle abort pulse to the divider
- div_done  in  1  divider result valid (one-cycle pulse)
- div_s  in  32  quotient
- div_r  in  32  remainder
- busy  out  1  an operation is in flight
- complete  out  1  HI/LO update visible this cycle (one-cycle pulse)
- hi  out  32  architectural HI
- lo  out  32  architectural LO

## Operation
- States: IDLE, MUL, DIV.
- `req_ready` = (state == IDLE) && !flush. `busy` = (state != IDLE).
- Accept condition: `req_valid` && `req_ready`.
- Accepting MULT/MULTU:
  - `op_x`/`op_y` are latched, `mul_signed` = (op == MULT), state goes to MUL, and the counter loads MUL_LAT.
  - `mul_start` is registered, so it is high in the cycle after accept.
- MUL state:
  - Counter decrements on each cycle after the start cycle.
  - When the counter reaches 0: HI ← `mul_result[63:32]`, LO ← `mul_result[31:0]`, then return to IDLE.
- Accepting DIV/DIVU:
  - Operands are latched, `div_signed` = (op == DIV).
  - If `req_y` == 0: no divider start, HI/LO are unchanged, `complete` pulses in the next cycle, and state stays IDLE.
  - Otherwise `div_start` pulses in the next cycle and state goes to DIV.
- DIV state: on `div_done`, HI ← `div_r`, LO ← `div_s`, then return to IDLE. There is no timeout.
- MTHI/MTLO:
  - HI (or LO) ← `req_x` at the accept edge; state stays IDLE.
  - `complete` pulses in the next cycle; the units are not started.
- NOP and reserved codes: accepted with no effect and no `complete`.
- Flush:
  - In MUL or DIV: next edge returns to IDLE, with no HI/LO write and no `complete`.
  - In DIV, `div_cancel` pulses in the cycle after the flush.
  - In IDLE: the presented request is ignored.
- Flush coinciding with the completion cycle (counter 0, or `div_done`): flush wins and HI/LO are unchanged.
- `complete` and the HI/LO write are registered together, so the new values are visible in the same cycle `complete` is high.

## Timing
- Reset values: state IDLE; `hi`, `lo`, `op_x`, `op_y` = 0; all pulse outputs, `mul_signed`, `div_signed`, `busy` = 0; `req_ready` = 1 (absent flush).
- Mult: accept in cycle T, `mul_start` in T+1, result sampled at the end of T+1+MUL_LAT, `complete` in T+2+MUL_LAT.
- Div: `complete` in the cycle after `div_done`.
- MTHI/MTLO and divide-by-zero: `complete` in T+1.
- Throughput: a new request is accepted no earlier than the `complete` cycle of the previous one; `req_ready` is high in that cycle.
- Reset asserted mid-operation forces all reset values immediately, regardless of clock.

## Structure
- Shared package `mips_muldiv_pkg`: op-code constants (`MD_NOP` .. `MD_MTLO`), state encoding, MUL_LAT default.
- One sub-module, `mips_hilo_regs`: HI/LO registers with independent write enables and a shared `complete` register.
- FSM, counter, and operand latches live in the top module.

## Test plan
- MULT x=0xFFFFFFFF, y=2, MUL_LAT=2, accept at T -> `mul_start` at T+1; `complete` at T+4; HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- MULTU with the same operands -> HI=0x00000001, LO=0xFFFFFFFE; `mul_signed`=0.
- DIV x=0xFFFFFFF9 (-7), y=2, model `div_done` 33 cycles after `div_start` -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; `busy` high throughout; `req_ready` low until `complete`.
- DIVU with y=0 -> no `div_start`; `complete` at T+1; HI/LO retain prior values.
- DIV in flight, `flush` asserted 5 cycles after start -> `div_cancel` pulse; IDLE on the next cycle; no `complete`; HI/LO unchanged. Repeat with `flush` coinciding with `div_done`: same result.
- MTHI 0x12345678, then MTLO 0x9ABCDEF0 back-to-back -> each `complete` follows its accept by one cycle; final HI=0x12345678, LO=0x9ABCDEF0. Async `rst` pulse mid-MUL -> HI=LO=0 and IDLE without a clock edge.

Source files
------------

// File: rtl/mips_muldiv_pkg.sv
// Shared definitions for the multiply/divide sequencing controller:
// operation codes, FSM state encoding and the default multiplier latency.
package mips_muldiv_pkg;

    localparam logic [2:0] MD_NOP   = 3'd0;
    localparam logic [2:0] MD_MULT  = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
    localparam logic [2:0] MD_MTHI  = 3'd5;
    localparam logic [2:0] MD_MTLO  = 3'd6;

    localparam int MUL_LAT_DEFAULT = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } md_state_e;

    // True for the two multiply operation codes.
    function automatic logic md_is_mul(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

    // True for the two divide operation codes.
    function automatic logic md_is_div(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/mips_hilo_regs.sv
// Architectural HI/LO registers. Each half has its own write enable; the
// complete flag is registered on the same edge as the data so that the new
// HI/LO values and the complete pulse become visible in the same cycle.
module mips_hilo_regs (
    input  logic        clk,
    input  logic        rst,
    input  logic        hi_we_i,
    input  logic [31:0] hi_wd_i,
    input  logic        lo_we_i,
    input  logic [31:0] lo_wd_i,
    input  logic        cmp_set_i,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        complete_o
);

    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        complete_q;

    // HI/LO storage and the one-cycle complete pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q       <= '0;
            lo_q       <= '0;
            complete_q <= 1'b0;
        end else begin
            if (hi_we_i) hi_q <= hi_wd_i;
            if (lo_we_i) lo_q <= lo_wd_i;
            complete_q <= cmp_set_i;
        end
    end

    assign hi_o       = hi_q;
    assign lo_o       = lo_q;
    assign complete_o = complete_q;

endmodule

// File: rtl/mips_muldiv_ctrl.sv
// Execute-stage multiply/divide sequencer. Accepts one HI/LO-class operation
// at a time, latches operands, launches the fixed-latency multiplier or the
// handshaked iterative divider, and commits results into HI/LO. A flush
// cancels whatever is in flight (or presented) without touching HI/LO.
module mips_muldiv_ctrl
    import mips_muldiv_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_x,
    input  logic [31:0] req_y,
    output logic        req_ready,
    input  logic        flush,
    output logic [31:0] op_x,
    output logic [31:0] op_y,
    output logic        mul_start,
    output logic        mul_signed,
    input  logic [63:0] mul_result,
    output logic        div_start,
    output logic        div_signed,
    output logic        div_cancel,
    input  logic        div_done,
    input  logic [31:0] div_s,
    input  logic [31:0] div_r,
    output logic        busy,
    output logic        complete,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    md_state_e   state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] opx_q, opx_d;
    logic [31:0] opy_q, opy_d;
    logic        mul_signed_q, mul_signed_d;
    logic        div_signed_q, div_signed_d;
    logic        mul_start_q, mul_start_d;
    logic        div_start_q, div_start_d;
    logic        div_cancel_q, div_cancel_d;

    logic        accept;
    logic        div_by_zero;
    logic        hi_we, lo_we, cmp_set;
    logic [31:0] hi_wd, lo_wd;

    assign req_ready   = (state_q == ST_IDLE) && !flush;
    assign accept      = req_valid && req_ready;
    assign div_by_zero = (req_y == 32'd0);

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // FSM next-state logic; flush always wins over completion.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (md_is_mul(req_op))                       state_d = ST_MUL;
                    else if (md_is_div(req_op) && !div_by_zero)  state_d = ST_DIV;
                end
            end
            ST_MUL: begin
                if (flush || (cnt_q == 4'd0)) state_d = ST_IDLE;
            end
            ST_DIV: begin
                if (flush || div_done) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: unit start/cancel requests, HI/LO writes and completion.
    always_comb begin
        mul_start_d  = 1'b0;
        div_start_d  = 1'b0;
        div_cancel_d = 1'b0;
        hi_we        = 1'b0;
        lo_we        = 1'b0;
        hi_wd        = 32'd0;
        lo_wd        = 32'd0;
        cmp_set      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (req_op)
                        MD_MULT, MD_MULTU: mul_start_d = 1'b1;
                        MD_DIV, MD_DIVU: begin
                            // Divide by zero leaves HI/LO untouched but still retires.
                            if (div_by_zero) cmp_set     = 1'b1;
                            else             div_start_d = 1'b1;
                        end
                        MD_MTHI: begin
                            hi_we   = 1'b1;
                            hi_wd   = req_x;
                            cmp_set = 1'b1;
                        end
                        MD_MTLO: begin
                            lo_we   = 1'b1;
                            lo_wd   = req_x;
                            cmp_set = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            ST_MUL: begin
                if (!flush && (cnt_q == 4'd0)) begin
                    hi_we   = 1'b1;
                    hi_wd   = mul_result[63:32];
                    lo_we   = 1'b1;
                    lo_wd   = mul_result[31:0];
                    cmp_set = 1'b1;
                end
            end
            ST_DIV: begin
                if (flush) begin
                    div_cancel_d = 1'b1;
                end else if (div_done) begin
                    hi_we   = 1'b1;
                    hi_wd   = div_r;
                    lo_we   = 1'b1;
                    lo_wd   = div_s;
                    cmp_set = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Latency counter, operand latches and signedness flags.
    always_comb begin
        cnt_d        = cnt_q;
        opx_d        = opx_q;
        opy_d        = opy_q;
        mul_signed_d = mul_signed_q;
        div_signed_d = div_signed_q;
        if (accept && md_is_mul(req_op)) begin
            cnt_d        = 4'(MUL_LAT);
            opx_d        = req_x;
            opy_d        = req_y;
            mul_signed_d = (req_op == MD_MULT);
        end else if (accept && md_is_div(req_op)) begin
            opx_d        = req_x;
            opy_d        = req_y;
            div_signed_d = (req_op == MD_DIV);
        end else if ((state_q == ST_MUL) && (cnt_q != 4'd0)) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    // Registered datapath latches and one-cycle unit pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q        <= 4'd0;
            opx_q        <= 32'd0;
            opy_q        <= 32'd0;
            mul_signed_q <= 1'b0;
            div_signed_q <= 1'b0;
            mul_start_q  <= 1'b0;
            div_start_q  <= 1'b0;
            div_cancel_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            opx_q        <= opx_d;
            opy_q        <= opy_d;
            mul_signed_q <= mul_signed_d;
            div_signed_q <= div_signed_d;
            mul_start_q  <= mul_start_d;
            div_start_q  <= div_start_d;
            div_cancel_q <= div_cancel_d;
        end
    end

    mips_hilo_regs u_hilo (
        .clk        (clk),
        .rst        (rst),
        .hi_we_i    (hi_we),
        .hi_wd_i    (hi_wd),
        .lo_we_i    (lo_we),
        .lo_wd_i    (lo_wd),
        .cmp_set_i  (cmp_set),
        .hi_o       (hi),
        .lo_o       (lo),
        .complete_o (complete)
    );

    assign busy       = (state_q != ST_IDLE);
    assign op_x       = opx_q;
    assign op_y       = opy_q;
    assign mul_start  = mul_start_q;
    assign mul_signed = mul_signed_q;
    assign div_start  = div_start_q;
    assign div_signed = div_signed_q;
    assign div_cancel = div_cancel_q;

endmodule

// File: tb/tb_mips_muldiv_ctrl.sv
// Directed bench for mips_muldiv_ctrl with a small fixed-latency multiplier
// model and a procedurally driven divider handshake.
module tb_mips_muldiv_ctrl;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [2:0]  req_op;
    logic [31:0] req_x, req_y;
    logic        req_ready;
    logic        flush;
    logic [31:0] op_x, op_y;
    logic        mul_start, mul_signed;
    logic [63:0] mul_result;
    logic        div_start, div_signed, div_cancel;
    logic        div_done;
    logic [31:0] div_s, div_r;
    logic        busy, complete;
    logic [31:0] hi, lo;

    int checks   = 0;
    int failures = 0;

    // Multiplier model operands, set by the stimulus.
    logic [31:0] mx, my;
    logic        ms;
    logic signed [63:0] prod;
    int mcnt = 0;

    always #5 clk = ~clk;

    mips_muldiv_ctrl #(.MUL_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op),
        .req_x(req_x), .req_y(req_y), .req_ready(req_ready), .flush(flush),
        .op_x(op_x), .op_y(op_y), .mul_start(mul_start), .mul_signed(mul_signed),
        .mul_result(mul_result), .div_start(div_start), .div_signed(div_signed),
        .div_cancel(div_cancel), .div_done(div_done), .div_s(div_s), .div_r(div_r),
        .busy(busy), .complete(complete), .hi(hi), .lo(lo)
    );

    // Product is only valid exactly MUL_LAT cycles after the start cycle.
    always @(posedge clk) begin
        if (mul_start)                     mcnt <= 1;
        else if (mcnt != 0 && mcnt < 20)   mcnt <= mcnt + 1;
        else                               mcnt <= 0;
    end

    always_comb begin
        if (ms) prod = $signed({{32{mx[31]}}, mx}) * $signed({{32{my[31]}}, my});
        else    prod = $signed({32'd0, mx} * {32'd0, my});
        mul_result = (mcnt == LAT) ? prod : 64'hDEADBEEF_DEADBEEF;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        req_valid = 1'b1;
        req_op    = op;
        req_x     = x;
        req_y     = y;
    endtask

    task automatic idle_req();
        req_valid = 1'b0;
        req_op    = 3'd0;
        req_x     = 32'd0;
        req_y     = 32'd0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        rst = 1'b1; flush = 1'b0; div_done = 1'b0; div_s = '0; div_r = '0;
        mx = '0; my = '0; ms = 1'b0;
        idle_req();
        tick(); tick();

        // Reset values
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_opx", op_x, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", req_ready, 1);
        check("rst_pulses", {mul_start, div_start, div_cancel, complete, mul_signed, div_signed}, 0);
        rst = 1'b0;
        tick();

        // MULT 0xFFFFFFFF * 2, accept in cycle T
        mx = 32'hFFFFFFFF; my = 32'd2; ms = 1'b1;
        present(3'd1, 32'hFFFFFFFF, 32'd2);
        check("mult_ready", req_ready, 1);
        tick(); idle_req();                       // T+1
        check("mult_start", mul_start, 1);
        check("mult_signed", mul_signed, 1);
        check("mult_busy", busy, 1);
        check("mult_opx", op_x, 32'hFFFFFFFF);
        check("mult_opy", op_y, 32'd2);
        tick();                                   // T+2
        check("mult_start_t2", mul_start, 0);
        tick();                                   // T+3
        check("mult_nocmp_t3", complete, 0);
        check("mult_ready_t3", req_ready, 0);
        tick();                                   // T+4
        check("mult_cmp", complete, 1);
        check("mult_hi", hi, 32'hFFFFFFFF);
        check("mult_lo", lo, 32'hFFFFFFFE);
        check("mult_ready_cmp", req_ready, 1);

        // MULTU with the same operands, accepted in the complete cycle
        ms = 1'b0;
        present(3'd2, 32'hFFFFFFFF, 32'd2);
        tick(); idle_req();
        check("multu_signed", mul_signed, 0);
        check("multu_start", mul_start, 1);
        tick(); tick(); tick();
        check("multu_cmp", complete, 1);
        check("multu_hi", hi, 32'h00000001);
        check("multu_lo", lo, 32'hFFFFFFFE);
        tick();
        check("multu_cmp_off", complete, 0);

        // DIV -7 / 2, divider done 33 cycles after start
        present(3'd3, 32'hFFFFFFF9, 32'd2);
        tick(); idle_req();                       // S
        check("div_start", div_start, 1);
        check("div_signed", div_signed, 1);
        bad = 0;
        for (int i = 1; i <= 32; i++) begin
            tick();
            if (!busy || req_ready || div_start || complete) bad++;
        end
        check("div_wait_busy", bad, 0);
        tick();                                   // S+33
        div_done = 1'b1; div_s = 32'hFFFFFFFD; div_r = 32'hFFFFFFFF;
        check("div_busy_done", busy, 1);
        tick(); div_done = 1'b0; div_s = '0; div_r = '0;
        check("div_cmp", complete, 1);
        check("div_lo", lo, 32'hFFFFFFFD);
        check("div_hi", hi, 32'hFFFFFFFF);
        check("div_idle", busy, 0);

        // DIVU by zero, accepted in the complete cycle
        present(3'd4, 32'd5, 32'd0);
        check("divz_ready", req_ready, 1);
        tick(); idle_req();
        check("divz_nostart", div_start, 0);
        check("divz_cmp", complete, 1);
        check("divz_busy", busy, 0);
        check("divz_hilo", {hi, lo}, {32'hFFFFFFFF, 32'hFFFFFFFD});
        check("divz_signed", div_signed, 0);
        tick();

        // DIV flushed 5 cycles after start
        present(3'd3, 32'd100, 32'd7);
        tick(); idle_req();                       // S
        check("dflush_start", div_start, 1);
        for (int i = 0; i < 5; i++) tick();       // S+5
        flush = 1'b1;
        check("dflush_ready", req_ready, 0);
        tick(); flush = 1'b0;
        check("dflush_cancel", div_cancel, 1);
        check("dflush_idle", busy, 0);
        check("dflush_nocmp", complete, 0);
        tick();
        check("dflush_cancel_off", div_cancel, 0);
        check("dflush_hilo", {hi, lo}, {32'hFFFFFFFF, 32'hFFFFFFFD});

        // DIV with flush coinciding with div_done
        present(3'd4, 32'd100, 32'd7);
        tick(); idle_req();
        tick(); tick();
        flush = 1'b1; div_done = 1'b1; div_s = 32'h11111111; div_r = 32'h22222222;
        tick(); flush = 1'b0; div_done = 1'b0;
        check("dfd_cancel", div_cancel, 1);
        check("dfd_nocmp", complete, 0);
        check("dfd_idle", busy, 0);
        check("dfd_hilo", {hi, lo}, {32'hFFFFFFFF, 32'hFFFFFFFD});

        // Flush in IDLE drops the presented request
        present(3'd5, 32'hCAFEF00D, 32'd0);
        flush = 1'b1;
        check("iflush_ready", req_ready, 0);
        tick(); flush = 1'b0; idle_req();
        check("iflush_nocmp", complete, 0);
        check("iflush_hi", hi, 32'hFFFFFFFF);

        // NOP is accepted without effect
        present(3'd0, 32'h5555AAAA, 32'd1);
        tick(); idle_req();
        check("nop_nocmp", complete, 0);
        check("nop_busy", busy, 0);

        // MTHI then MTLO back-to-back
        present(3'd5, 32'h12345678, 32'd0);
        tick();
        check("mthi_cmp", complete, 1);
        check("mthi_hi", hi, 32'h12345678);
        present(3'd6, 32'h9ABCDEF0, 32'd0);
        check("mtlo_ready", req_ready, 1);
        tick(); idle_req();
        check("mtlo_cmp", complete, 1);
        check("mtlo_hilo", {hi, lo}, {32'h12345678, 32'h9ABCDEF0});
        tick();
        check("mtlo_cmp_off", complete, 0);

        // MULT flushed in its result cycle
        mx = 32'd3; my = 32'd4; ms = 1'b1;
        present(3'd1, 32'd3, 32'd4);
        tick(); idle_req();                       // T+1
        tick(); tick();                           // T+3, counter at zero
        flush = 1'b1;
        tick(); flush = 1'b0;
        check("mflush_nocmp", complete, 0);
        check("mflush_idle", busy, 0);
        check("mflush_hilo", {hi, lo}, {32'h12345678, 32'h9ABCDEF0});

        // Asynchronous reset mid-MUL
        present(3'd1, 32'd3, 32'd4);
        tick(); idle_req();
        tick();
        check("arst_pre_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        check("arst_hilo", {hi, lo}, 64'd0);
        check("arst_busy", busy, 0);
        check("arst_ready", req_ready, 1);
        check("arst_opx", op_x, 0);
        rst = 1'b0;
        tick(); tick();
        check("arst_after_cmp", complete, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
